// File: rtl/bmem_line_adaptor_if.sv
// Line-side and bmem-side signal bundle for bmem_line_adaptor.
//   line_*  : L2 request (addr/read/write/wdata) and completion (rdata/resp)
//   bmem_*  : DRAM burst command (address/read/write/wdata) and return (rdata/resp)
// Modports:
//   master : the adaptor (drives bmem commands and line completion)
//   slave  : the cache and memory side (drives line requests and bmem returns)
interface bmem_line_adaptor_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] line_addr;
  logic                  line_read;
  logic                  line_write;
  logic [LINE_WIDTH-1:0] line_wdata;
  logic [LINE_WIDTH-1:0] line_rdata;
  logic                  line_resp;
  logic [ADDR_WIDTH-1:0] bmem_address;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BEAT_WIDTH-1:0] bmem_wdata;
  logic [BEAT_WIDTH-1:0] bmem_rdata;
  logic                  bmem_resp;

  modport master (
    input  line_addr, line_read, line_write, line_wdata, bmem_rdata, bmem_resp,
    output line_rdata, line_resp, bmem_address, bmem_read, bmem_write, bmem_wdata
  );

  modport slave (
    output line_addr, line_read, line_write, line_wdata, bmem_rdata, bmem_resp,
    input  line_rdata, line_resp, bmem_address, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/bmem_line_adaptor.sv
// Bridge from one-line L2 requests to a single bmem burst of BURST_LEN beats.
// Writes are registered and streamed out beat 0 first; reads are reassembled
// beat by beat into a registered line and returned with a one-cycle line_resp.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : bmem_line_adaptor_if.master (line request/response, bmem burst)
module bmem_line_adaptor #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  bmem_line_adaptor_if.master  bus
);
  localparam int unsigned BURST_LEN = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CntW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned OffW      = $clog2(LINE_WIDTH / 8);
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdData,
    StWrData,
    StWrWait,
    StDone
  } state_e;

  state_e                               state_q, state_d;
  logic [CntW-1:0]                      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  // One buffer serves both directions: write line to stream, or read line being built.
  logic [BURST_LEN-1:0][BEAT_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0]                addr_aligned;

  assign addr_aligned = {bus.line_addr[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        // Write has priority over a simultaneous read.
        if (bus.line_write) begin
          addr_d  = addr_aligned;
          line_d  = bus.line_wdata;
          cnt_d   = '0;
          state_d = StWrData;
        end else if (bus.line_read) begin
          addr_d  = addr_aligned;
          state_d = StRdReq;
        end
      end
      StRdReq: begin
        cnt_d   = '0;
        state_d = StRdData;
      end
      StRdData: begin
        if (bus.bmem_resp) begin
          line_d[cnt_q] = bus.bmem_rdata;
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWrData: begin
        if (cnt_q == LastBeat) begin
          cnt_d   = '0;
          state_d = StWrWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrWait: begin
        if (bus.bmem_resp) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode registered state only; nothing from line_* reaches bmem_* combinationally.
  assign bus.line_resp    = (state_q == StDone);
  assign bus.line_rdata   = line_q;
  assign bus.bmem_read    = (state_q == StRdReq);
  assign bus.bmem_write   = (state_q == StWrData);
  assign bus.bmem_address = ((state_q == StRdReq) || (state_q == StWrData)) ? addr_q : '0;
  assign bus.bmem_wdata   = (state_q == StWrData) ? line_q[cnt_q] : '0;
endmodule

// File: tb/tb_bmem_line_adaptor.sv
// Self-checking bench for bmem_line_adaptor: directed read/write/reset/stray-response
// scenarios followed by randomized bursts, checked against expectations derived
// from line/beat arithmetic and cycle positions.
module tb_bmem_line_adaptor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bmem_line_adaptor_if bus ();

  bmem_line_adaptor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 256'(obs), 256'(exp));
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk(tag, 256'(obs), 256'(exp));
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk(tag, 256'(obs), 256'(exp));
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~32'h1f;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_all_zero(input string tag);
    chk1({tag, "_resp"}, bus.line_resp, 1'b0);
    chk1({tag, "_bread"}, bus.bmem_read, 1'b0);
    chk1({tag, "_bwrite"}, bus.bmem_write, 1'b0);
    chk32({tag, "_baddr"}, bus.bmem_address, 32'h0);
    chk64({tag, "_bwdata"}, bus.bmem_wdata, 64'h0);
    chk({tag, "_rdata"}, bus.line_rdata, 256'h0);
  endtask

  // Read of one line; memory returns beat i of 'line' with 'gap' idle cycles
  // between beats (negative gap: random 0..3 per beat).
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int gap);
    int g;
    bus.line_addr = addr;
    bus.line_read = 1'b1;
    step();
    chk1("rd_cmd", bus.bmem_read, 1'b1);
    chk32("rd_addr", bus.bmem_address, align(addr));
    chk1("rd_nowrite", bus.bmem_write, 1'b0);
    bus.line_addr = $urandom;
    step();
    chk1("rd_pulse_once", bus.bmem_read, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.bmem_resp  = 1'b1;
      bus.bmem_rdata = line[i*64 +: 64];
      step();
      bus.bmem_resp  = 1'b0;
      bus.bmem_rdata = rand64();
      if (i < 3) begin
        chk1("rd_early_resp", bus.line_resp, 1'b0);
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) begin
          step();
          chk1("rd_gap_resp", bus.line_resp, 1'b0);
        end
      end
    end
    chk1("rd_resp", bus.line_resp, 1'b1);
    chk("rd_line", bus.line_rdata, line);
    bus.line_read = 1'b0;
    step();
    chk1("rd_resp_single", bus.line_resp, 1'b0);
  endtask

  // Write of one line; bmem_resp arrives after 'delay' idle cycles of WR_WAIT.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int delay,
                          input bit both, input bit stray);
    bus.line_addr  = addr;
    bus.line_write = 1'b1;
    bus.line_read  = both;
    bus.line_wdata = line;
    step();
    // Upstream changes after acceptance must not leak into the burst.
    bus.line_wdata = rand_line();
    bus.line_addr  = $urandom;
    for (int i = 0; i < 4; i++) begin
      chk1("wr_strobe", bus.bmem_write, 1'b1);
      chk32("wr_addr", bus.bmem_address, align(addr));
      chk64("wr_beat", bus.bmem_wdata, line[i*64 +: 64]);
      chk1("wr_noread", bus.bmem_read, 1'b0);
      bus.bmem_resp = stray && (i == 1);
      step();
      bus.bmem_resp = 1'b0;
    end
    chk1("wr_strobe_end", bus.bmem_write, 1'b0);
    chk1("wr_noread_end", bus.bmem_read, 1'b0);
    repeat (delay) begin
      chk1("wr_wait_resp", bus.line_resp, 1'b0);
      step();
    end
    bus.bmem_resp = 1'b1;
    step();
    bus.bmem_resp = 1'b0;
    chk1("wr_resp", bus.line_resp, 1'b1);
    bus.line_write = 1'b0;
    bus.line_read  = 1'b0;
    step();
    chk1("wr_resp_single", bus.line_resp, 1'b0);
  endtask

  initial begin
    logic [255:0] ref_line;
    logic [255:0] tmp;
    bus.line_addr  = '0;
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    bus.line_wdata = '0;
    bus.bmem_rdata = '0;
    bus.bmem_resp  = 1'b0;

    rst_n = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    ref_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h1000_0040, ref_line, 0);
    do_read(32'h1000_0040, ref_line, 2);

    do_write(32'h0000_00A4, rand_line(), 10, 1'b0, 1'b1);
    do_write($urandom, rand_line(), 3, 1'b1, 1'b0);

    // Reset in the middle of a read, after two beats.
    tmp = rand_line();
    bus.line_addr = 32'h2000_0000;
    bus.line_read = 1'b1;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      bus.bmem_resp  = 1'b1;
      bus.bmem_rdata = tmp[i*64 +: 64];
      step();
    end
    bus.bmem_resp = 1'b0;
    bus.line_read = 1'b0;
    rst_n = 1'b0;
    step();
    check_all_zero("midrst");
    rst_n = 1'b1;
    for (int i = 2; i < 4; i++) begin
      bus.bmem_resp  = 1'b1;
      bus.bmem_rdata = tmp[i*64 +: 64];
      step();
      chk1("midrst_noresp", bus.line_resp, 1'b0);
      chk1("midrst_noread", bus.bmem_read, 1'b0);
    end
    bus.bmem_resp = 1'b0;
    step();
    chk1("midrst_quiet", bus.line_resp, 1'b0);
    do_read(32'h3000_0123, rand_line(), -1);

    // Stray responses while idle.
    bus.bmem_resp  = 1'b1;
    bus.bmem_rdata = rand64();
    repeat (3) begin
      step();
      chk1("stray_resp", bus.line_resp, 1'b0);
      chk1("stray_read", bus.bmem_read, 1'b0);
      chk1("stray_write", bus.bmem_write, 1'b0);
    end
    bus.bmem_resp = 1'b0;
    do_read(32'h0000_0fff, rand_line(), 1);

    // Randomized mix.
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_read($urandom, rand_line(), -1);
      else
        do_write($urandom, rand_line(), int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bmem_line_adaptor.md
# bmem_line_adaptor

Initiator-side bridge between the L2 caches (one 256-bit line per request) and the DRAM burst interface (bmem_itf). It registers a line read or write from the cache and converts it into one bmem burst of BURST_LEN beats. For writes it drives the beats out; for reads it reassembles the returned beats into a line. It is the requester that `burst_memory` serves, and it sits in `mp4` between the L2/arbiter and the `bmem_*` top-level ports.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width
- LINE_WIDTH, 256, cache line width in bits
- BEAT_WIDTH, 64, bmem data width in bits; BURST_LEN = LINE_WIDTH/BEAT_WIDTH (4 by default)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset; synchronous and active-low
- line_addr  input  ADDR_WIDTH  line byte address from L2
- line_read  input  1  line read request, level; held until line_resp
- line_write  input  1  line write request, level; held until line_resp
- line_wdata  input  LINE_WIDTH  write line; beat i = bits [i*BEAT_WIDTH +: BEAT_WIDTH]
- line_rdata  output  LINE_WIDTH  assembled read line; valid while line_resp is high
- line_resp  output  1  one-cycle completion pulse
- bmem_address  output  ADDR_WIDTH  burst address, line-aligned
- bmem_read  output  1  read command, one cycle per burst
- bmem_write  output  1  write strobe, high for BURST_LEN consecutive cycles
- bmem_wdata  output  BEAT_WIDTH  write beat
- bmem_rdata  input  BEAT_WIDTH  read beat, valid when bmem_resp is high
- bmem_resp  input  1  read beat valid, or write-complete pulse

## Operation
- State machine: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_WAIT, DONE.
- IDLE:
  - If line_write: latch the address and line_wdata, then go to WR_DATA.
  - Else if line_read: latch the address, then go to RD_REQ.
  - Write wins if both requests are high at once.
  - Latched address has the low log2(LINE_WIDTH/8) bits forced to 0.
- RD_REQ: bmem_read=1 and bmem_address=latched address for exactly one cycle; then RD_DATA with beat counter = 0.
- RD_DATA:
  - Each cycle with bmem_resp=1, store bmem_rdata into beat slot[counter] and increment counter.
  - Gaps (bmem_resp=0) are allowed; counter holds.
  - After beat BURST_LEN-1 is stored, go to DONE.
- WR_DATA:
  - bmem_write=1 and bmem_address=latched address for BURST_LEN consecutive cycles.
  - bmem_wdata = beat[counter], beats 0..BURST_LEN-1 in order.
  - Then WR_WAIT.
- WR_WAIT: wait for bmem_resp=1, then DONE.
- DONE: line_resp=1 for one cycle. On a read, line_rdata holds the assembled line. Then IDLE.
- bmem_resp in IDLE, RD_REQ, WR_DATA or DONE is ignored: no state change, no data capture.
- Requests are not accepted in DONE. Upstream drops its request in the line_resp cycle, so IDLE never re-triggers on a stale request.
- The counter is log2(BURST_LEN) bits wide and wraps to 0 on the terminal beat.
- Line data is internally registered. Upstream changes to line_wdata or line_addr after acceptance have no effect.

## Timing
- Reset (rst_n=0 at a rising edge), effective next cycle:
  - State IDLE, counter 0.
  - line_resp=0, bmem_read=0, bmem_write=0, bmem_address=0, bmem_wdata=0, line_rdata=0.
- Reset mid-burst aborts the transfer. Beats returned afterwards arrive while in IDLE and are ignored.
- All bmem_* and line_* outputs come from registers or decode of registered state. There is no combinational path from line_* inputs to bmem_* outputs.
- Read accepted at cycle N:
  - bmem_read is high in cycle N+1.
  - If the last beat arrives in cycle M, line_resp is high in cycle M+1.
  - With zero-gap memory returning beats at N+2..N+5, line_resp is at N+6.
- Write accepted at cycle N:
  - bmem_write is high in cycles N+1..N+BURST_LEN.
  - If bmem_resp arrives in cycle K (K > N+BURST_LEN), line_resp is high in cycle K+1.
- Earliest next acceptance is the cycle after line_resp (back-to-back requests, one idle cycle apart).

## Test plan
- Read with zero-gap memory: line_read at 0x1000_0040, memory returns beats 0x11..1, 0x22..2, 0x33..3, 0x44..4 at N+2..N+5.
  - bmem_read pulses once at N+1 with address 0x1000_0040.
  - line_resp at N+6, line_rdata = {0x44..4, 0x33..3, 0x22..2, 0x11..1}.
- Read with gaps: same beats, each separated by 2 idle cycles.
  - Same line_rdata; line_resp exactly one cycle after the 4th beat.
- Write: line_write to 0x0000_00A4 with line = {D3, D2, D1, D0}.
  - bmem_address = 0x0000_00A0 for 4 cycles, bmem_wdata = D0, D1, D2, D3 in order.
  - bmem_resp 10 cycles later gives line_resp one cycle after that.
- Simultaneous line_read and line_write: a write burst is issued and bmem_read never asserts.
- Reset mid-read after 2 beats:
  - All outputs are 0 the next cycle.
  - The remaining 2 beats produce no line_resp.
  - A following read completes correctly.
- Stray bmem_resp while in IDLE: no line_resp, state remains IDLE.
